// File: rtl/mp1_cache_types.sv
// Shared types for the mp1 direct-mapped write-through L1 cache.
// One 16-bit word per line; the index comes from address bits above the byte offset.
package mp1_cache_types;

   localparam int DEF_IDX_BITS = 3;
   localparam int TAG_BITS     = 15 - DEF_IDX_BITS;

   typedef logic [TAG_BITS-1:0]     tag_t;
   typedef logic [DEF_IDX_BITS-1:0] idx_t;
   typedef logic [15:0]             word_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PREAD  = 2'd1,
      PWRITE = 2'd2,
      RESP   = 2'd3
   } cache_state_t;

endpackage

// File: rtl/mp1_cache_array.sv
// Valid/tag/data storage for the mp1 cache.
// Reads are combinational by index. Writes are synchronous with a per-byte data enable.
module mp1_cache_array
   import mp1_cache_types::*;
#(
   parameter int IDX_BITS = DEF_IDX_BITS,
   parameter int TAG_W    = 15 - IDX_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [1:0]          wr_be,
   input  logic [IDX_BITS-1:0] wr_idx,
   input  logic [TAG_W-1:0]    wr_tag,
   input  word_t               wr_data,
   input  logic [IDX_BITS-1:0] rd_idx,
   output logic                rd_valid,
   output logic [TAG_W-1:0]    rd_tag,
   output word_t               rd_data
);

   localparam int LINES = 1 << IDX_BITS;

   logic [LINES-1:0] valid_r;
   logic [TAG_W-1:0] tag_r  [LINES];
   word_t            data_r [LINES];

   // valid bits: the only state that is cleared by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= {LINES{1'b0}};
      end else if (wr_en) begin
         valid_r[wr_idx] <= 1'b1;
      end
   end

   // tag and data storage; a partial-mask write to a hit line rewrites the same tag
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_r[wr_idx] <= wr_tag;
         if (wr_be[0]) data_r[wr_idx][7:0]  <= wr_data[7:0];
         if (wr_be[1]) data_r[wr_idx][15:8] <= wr_data[15:8];
      end
   end

   assign rd_valid = valid_r[rd_idx];
   assign rd_tag   = tag_r[rd_idx];
   assign rd_data  = data_r[rd_idx];

endmodule

// File: rtl/mp1_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 cache between the mp1 core and physical memory.
// Read hits complete without touching memory. Misses and all writes run one memory transaction.
module mp1_cache
   import mp1_cache_types::*;
#(
   parameter int IDX_BITS = DEF_IDX_BITS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_byte_enable,
   input  logic [15:0] mem_address,
   input  logic [15:0] mem_wdata,
   output logic        mem_resp,
   output logic [15:0] mem_rdata,
   output logic        pmem_read,
   output logic        pmem_write,
   output logic [1:0]  pmem_wmask,
   output logic [15:0] pmem_address,
   output logic [15:0] pmem_wdata,
   input  logic        pmem_resp,
   input  logic [15:0] pmem_rdata
);

   localparam int TAG_W = 15 - IDX_BITS;

   cache_state_t        state_r, next_state_s;
   logic                mem_resp_r, pmem_read_r, pmem_write_r;
   logic [1:0]          pmem_wmask_r;
   logic [15:0]         pmem_address_r, pmem_wdata_r, rdata_r;
   logic [15:0]         sel_addr_s;
   logic                arr_valid_s, hit_s, arr_we_s;
   logic [1:0]          arr_be_s;
   logic [TAG_W-1:0]    arr_tag_s;
   word_t               arr_rdata_s, arr_wdata_s;

   // Outside IDLE the registered pmem address doubles as the latched request address.
   assign sel_addr_s = (state_r == IDLE) ? mem_address : pmem_address_r;
   assign hit_s      = arr_valid_s && (arr_tag_s == sel_addr_s[15:IDX_BITS+1]);

   mp1_cache_array #(.IDX_BITS(IDX_BITS), .TAG_W(TAG_W)) u_array (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (arr_we_s),
      .wr_be    (arr_be_s),
      .wr_idx   (sel_addr_s[IDX_BITS:1]),
      .wr_tag   (sel_addr_s[15:IDX_BITS+1]),
      .wr_data  (arr_wdata_s),
      .rd_idx   (sel_addr_s[IDX_BITS:1]),
      .rd_valid (arr_valid_s),
      .rd_tag   (arr_tag_s),
      .rd_data  (arr_rdata_s)
   );

   // next-state decode; RESP never samples the core, so a held request is not re-issued
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (mem_write)     next_state_s = PWRITE;
            else if (mem_read) next_state_s = hit_s ? RESP : PREAD;
            else               next_state_s = IDLE;
         end
         PREAD:   next_state_s = pmem_resp ? RESP : PREAD;
         PWRITE:  next_state_s = pmem_resp ? RESP : PWRITE;
         RESP:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // array update: full fill on read completion, byte merge on a write hit, never during reset
   always_comb begin
      arr_we_s    = 1'b0;
      arr_be_s    = 2'b00;
      arr_wdata_s = pmem_rdata;
      if (!rst && pmem_resp && (state_r == PREAD)) begin
         arr_we_s = 1'b1;
         arr_be_s = 2'b11;
      end else if (!rst && pmem_resp && (state_r == PWRITE) && hit_s) begin
         arr_we_s    = 1'b1;
         arr_be_s    = pmem_wmask_r;
         arr_wdata_s = pmem_wdata_r;
      end else begin
         arr_we_s = 1'b0;
      end
   end

   // state, registered handshakes and request latches
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= IDLE;
         mem_resp_r     <= 1'b0;
         rdata_r        <= 16'h0000;
         pmem_read_r    <= 1'b0;
         pmem_write_r   <= 1'b0;
         pmem_wmask_r   <= 2'b00;
         pmem_address_r <= 16'h0000;
         pmem_wdata_r   <= 16'h0000;
      end else begin
         state_r      <= next_state_s;
         mem_resp_r   <= (next_state_s == RESP);
         pmem_read_r  <= (next_state_s == PREAD);
         pmem_write_r <= (next_state_s == PWRITE);
         case (state_r)
            IDLE: begin
               if (mem_write) begin
                  pmem_address_r <= mem_address;
                  pmem_wdata_r   <= mem_wdata;
                  pmem_wmask_r   <= mem_byte_enable;
               end else if (mem_read) begin
                  if (hit_s) rdata_r <= arr_rdata_s;
                  else       pmem_address_r <= {mem_address[15:1], 1'b0};
               end
            end
            PREAD: begin
               if (pmem_resp) rdata_r <= pmem_rdata;
            end
            default: ;
         endcase
      end
   end

   assign mem_resp     = mem_resp_r;
   assign mem_rdata    = rdata_r;
   assign pmem_read    = pmem_read_r;
   assign pmem_write   = pmem_write_r;
   assign pmem_wmask   = pmem_wmask_r;
   assign pmem_address = pmem_address_r;
   assign pmem_wdata   = pmem_wdata_r;

endmodule

// File: tb/tb_mp1_cache.sv
// Directed bench for mp1_cache with a physical memory model that answers 3 cycles after a request.
module tb_mp1_cache;

   logic        clk = 1'b0;
   logic        rst, mem_read, mem_write, mem_resp;
   logic [1:0]  mem_byte_enable, pmem_wmask;
   logic [15:0] mem_address, mem_wdata, mem_rdata;
   logic        pmem_read, pmem_write, pmem_resp;
   logic [15:0] pmem_address, pmem_wdata, pmem_rdata;

   int checks   = 0;
   int failures = 0;

   logic [15:0] pm [0:127];
   logic        mem_init;
   int          lat_cnt;

   always #5 clk = ~clk;

   mp1_cache dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
      .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_resp(mem_resp), .mem_rdata(mem_rdata),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
   );

   // memory model: pmem_resp pulses 3 cycles after a request appears; a dropped request is forgotten
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 128; i++) pm[i] <= 16'h0000;
         pm[8]      <= 16'h1234;
         pm[16]     <= 16'h7777;
         pmem_resp  <= 1'b0;
         pmem_rdata <= 16'h0000;
         lat_cnt    <= 0;
      end else if ((pmem_read || pmem_write) && !pmem_resp) begin
         if (lat_cnt == 2) begin
            pmem_resp  <= 1'b1;
            lat_cnt    <= 0;
            pmem_rdata <= pm[pmem_address[7:1]];
            if (pmem_write && pmem_wmask[0]) pm[pmem_address[7:1]][7:0]  <= pmem_wdata[7:0];
            if (pmem_write && pmem_wmask[1]) pm[pmem_address[7:1]][15:8] <= pmem_wdata[15:8];
         end else begin
            lat_cnt <= lat_cnt + 1;
         end
      end else begin
         pmem_resp <= 1'b0;
         lat_cnt   <= 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // n counts falling edges from the request cycle: a hit answers on the 2nd, a miss one after pmem_resp
   task automatic do_read(input logic [15:0] addr, input logic [15:0] exp_data,
                          input int exp_preads, input bit exp_hit);
      int n, n_pr, reads;
      bit prev, done;
      @(posedge clk); #1;
      mem_read = 1'b1; mem_address = addr;
      n = 0; n_pr = -10; reads = 0; prev = 1'b0; done = 1'b0;
      while (!done && n < 40) begin
         @(negedge clk); n++;
         if (pmem_read && !prev) begin
            reads++;
            check("rd_pmem_addr", {16'h0000, pmem_address}, {16'h0000, addr[15:1], 1'b0});
         end
         prev = pmem_read;
         if (pmem_resp) n_pr = n;
         if (mem_resp) begin
            done = 1'b1;
            check("rd_data", {16'h0000, mem_rdata}, {16'h0000, exp_data});
         end
      end
      check("rd_done", {31'd0, done}, 32'd1);
      check("rd_pmem_reads", reads, exp_preads);
      if (exp_hit) check("rd_hit_latency", n, 32'd2);
      else         check("rd_miss_latency", n, n_pr + 1);
      @(posedge clk); #1;
      mem_read = 1'b0;
      @(negedge clk);
      check("rd_resp_single", {31'd0, mem_resp}, 32'd0);
   endtask

   task automatic do_write(input logic [15:0] addr, input logic [15:0] data, input logic [1:0] be);
      int n, n_pr, writes;
      bit prev, done;
      @(posedge clk); #1;
      mem_write = 1'b1; mem_address = addr; mem_wdata = data; mem_byte_enable = be;
      n = 0; n_pr = -10; writes = 0; prev = 1'b0; done = 1'b0;
      while (!done && n < 40) begin
         @(negedge clk); n++;
         if (pmem_write && !prev) begin
            writes++;
            check("wr_pmem_addr", {16'h0000, pmem_address}, {16'h0000, addr});
            check("wr_pmem_wdata", {16'h0000, pmem_wdata}, {16'h0000, data});
            check("wr_pmem_wmask", {30'd0, pmem_wmask}, {30'd0, be});
         end
         prev = pmem_write;
         if (pmem_read) check("wr_no_pmem_read", 32'd1, 32'd0);
         if (pmem_resp) n_pr = n;
         if (mem_resp) done = 1'b1;
      end
      check("wr_done", {31'd0, done}, 32'd1);
      check("wr_pmem_writes", writes, 32'd1);
      check("wr_latency", n, n_pr + 1);
      @(posedge clk); #1;
      mem_write = 1'b0; mem_byte_enable = 2'b00;
      @(negedge clk);
      check("wr_resp_single", {31'd0, mem_resp}, 32'd0);
   endtask

   initial begin
      int n;
      rst = 1'b1; mem_init = 1'b1;
      mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 2'b00;
      mem_address = 16'h0000; mem_wdata = 16'h0000;
      repeat (2) @(posedge clk);
      #1 mem_init = 1'b0;
      @(negedge clk);
      check("rst_mem_resp", {31'd0, mem_resp}, 32'd0);
      check("rst_mem_rdata", {16'h0000, mem_rdata}, 32'd0);
      check("rst_pmem_read", {31'd0, pmem_read}, 32'd0);
      check("rst_pmem_write", {31'd0, pmem_write}, 32'd0);
      check("rst_pmem_wmask", {30'd0, pmem_wmask}, 32'd0);
      check("rst_pmem_address", {16'h0000, pmem_address}, 32'd0);
      check("rst_pmem_wdata", {16'h0000, pmem_wdata}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      // cold miss, then hit
      do_read(16'h0010, 16'h1234, 1, 1'b0);
      do_read(16'h0010, 16'h1234, 0, 1'b1);

      // upper-byte write hit merges into the line: 0x1234 -> 0xAB34
      do_write(16'h0010, 16'hABCD, 2'b10);
      do_read(16'h0010, 16'hAB34, 0, 1'b1);

      // 0x0010 and 0x0020 share index 0 with different tags
      do_read(16'h0020, 16'h7777, 1, 1'b0);
      do_read(16'h0010, 16'hAB34, 1, 1'b0);
      do_read(16'h0020, 16'h7777, 1, 1'b0);

      // write miss does not allocate
      do_write(16'h0042, 16'h5555, 2'b11);
      do_read(16'h0042, 16'h5555, 1, 1'b0);

      // empty mask still goes to memory and leaves the line alone
      do_read(16'h0010, 16'hAB34, 1, 1'b0);
      do_write(16'h0010, 16'hFFFF, 2'b00);
      do_read(16'h0010, 16'hAB34, 0, 1'b1);

      // reset while a fill is outstanding
      @(posedge clk); #1;
      mem_read = 1'b1; mem_address = 16'h0020;
      n = 0;
      while (!pmem_read && n < 10) begin
         @(negedge clk); n++;
      end
      check("rstmid_pread_seen", {31'd0, pmem_read}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1; mem_read = 1'b0;
      @(posedge clk); #1;
      check("rstmid_pread_drop", {31'd0, pmem_read}, 32'd0);
      check("rstmid_no_resp", {31'd0, mem_resp}, 32'd0);
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("rstmid_quiet", {30'd0, mem_resp, pmem_read}, 32'd0);
      end
      do_read(16'h0020, 16'h7777, 1, 1'b0);
      do_read(16'h0010, 16'hAB34, 1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
